// File: rtl/alu_seq_param.sv
// alu_seq_param: registered ALU with a valid/ready operand handshake.
// Logic and arithmetic ops finish in one cycle; shifts/rotates step one bit per cycle.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready is high only in IDLE
//   in1, in2, im, op    operand A, operand B, shift count, opcode
//   out_valid,out_ready result handshake; res and flags hold until consumed
//   res, CF/ZF/SF/OF    result register and flag registers
//   busy                high while shift steps remain
module alu_seq_param #(
    parameter int WIDTH = 8,
    parameter int SH_W  = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [SH_W-1:0]  im,
    input  logic [4:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             CF,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    localparam logic [4:0] OP_ADD   = 5'h01;
    localparam logic [4:0] OP_AND   = 5'h02;
    localparam logic [4:0] OP_SUB   = 5'h03;
    localparam logic [4:0] OP_OR    = 5'h04;
    localparam logic [4:0] OP_XOR   = 5'h05;
    localparam logic [4:0] OP_MOV   = 5'h06;
    localparam logic [4:0] OP_ADC   = 5'h07;
    localparam logic [4:0] OP_NOT   = 5'h08;
    localparam logic [4:0] OP_SAR   = 5'h09;
    localparam logic [4:0] OP_SLR   = 5'h0A;
    localparam logic [4:0] OP_SAL   = 5'h0B;
    localparam logic [4:0] OP_SLL   = 5'h0C;
    localparam logic [4:0] OP_ROL   = 5'h0D;
    localparam logic [4:0] OP_ROR   = 5'h0E;
    localparam logic [4:0] OP_SHOWR = 5'h1F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q, w_q;
    logic [4:0]       op_q;
    logic [SH_W-1:0]  cnt_q;
    logic             wcf_q;

    logic accept, in_is_sh;

    assign accept   = in_valid && in_ready;
    assign in_is_sh = (op >= OP_SAR) && (op <= OP_ROR);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = (in_is_sh && im != '0) ? S_SHIFT : S_EXEC;
            end
            S_EXEC:  state_nxt = S_DONE;
            S_SHIFT: if (cnt_q == '0) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state == S_SHIFT) && (cnt_q != '0);
    end

    // Single-cycle datapath. ex_wr/ex_fl/ex_zs select which of
    // res, {CF,OF} and {ZF,SF} the op is allowed to update.
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] ex_res;
    logic             ex_cf, ex_of, ex_wr, ex_fl, ex_zs, cin;

    assign cin = (op_q == OP_ADC) && CF;
    assign sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    assign dif = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        ex_res = res;
        ex_cf  = CF;
        ex_of  = OF;
        ex_wr  = 1'b1;
        ex_fl  = 1'b1;
        ex_zs  = 1'b1;
        case (op_q)
            OP_ADD, OP_ADC: begin
                ex_res = sum[MSB:0];
                ex_cf  = sum[WIDTH];
                ex_of  = (a_q[MSB] == b_q[MSB]) &&
                         (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                ex_res = dif[MSB:0];
                ex_cf  = dif[WIDTH];
                ex_of  = (a_q[MSB] != b_q[MSB]) &&
                         (dif[MSB] != a_q[MSB]);
            end
            OP_AND: begin
                ex_res = a_q & b_q;
                ex_cf  = 1'b0;
                ex_of  = 1'b0;
            end
            OP_OR: begin
                ex_res = a_q | b_q;
                ex_cf  = 1'b0;
                ex_of  = 1'b0;
            end
            OP_XOR: begin
                ex_res = a_q ^ b_q;
                ex_cf  = 1'b0;
                ex_of  = 1'b0;
            end
            OP_NOT: begin
                ex_res = ~a_q;
                ex_cf  = 1'b0;
                ex_of  = 1'b0;
            end
            OP_MOV: begin
                ex_res = b_q;
                ex_fl  = 1'b0;
                ex_zs  = 1'b0;
            end
            OP_SHOWR: begin
                ex_res = a_q;
                ex_fl  = 1'b0;
                ex_zs  = 1'b0;
            end
            // Zero-count shift: pass operand, keep CF, clear OF
            OP_SAR, OP_SLR, OP_SAL, OP_SLL, OP_ROL, OP_ROR: begin
                ex_res = a_q;
                ex_of  = 1'b0;
            end
            default: begin
                ex_wr = 1'b0;
                ex_fl = 1'b0;
                ex_zs = 1'b0;
            end
        endcase
    end

    // One shift/rotate step on the working register
    logic [WIDTH-1:0] st_w;
    logic             st_c, sh_of;

    always_comb begin
        st_w = w_q;
        st_c = wcf_q;
        case (op_q)
            OP_SAR: begin
                st_w = {w_q[MSB], w_q[MSB:1]};
                st_c = w_q[0];
            end
            OP_SLR: begin
                st_w = {1'b0, w_q[MSB:1]};
                st_c = w_q[0];
            end
            OP_SAL, OP_SLL: begin
                st_w = {w_q[MSB-1:0], 1'b0};
                st_c = w_q[MSB];
            end
            OP_ROL: begin
                st_w = {w_q[MSB-1:0], w_q[MSB]};
                st_c = w_q[MSB];
            end
            OP_ROR: begin
                st_w = {w_q[0], w_q[MSB:1]};
                st_c = w_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_SAR:  sh_of = 1'b0;
            OP_SLR:  sh_of = a_q[MSB];
            default: sh_of = a_q[MSB] ^ w_q[MSB];
        endcase
    end

    // Operand latches, shift working state, result and flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            w_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
            wcf_q <= 1'b0;
            res   <= '0;
            CF    <= 1'b0;
            ZF    <= 1'b0;
            SF    <= 1'b0;
            OF    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q   <= in1;
                        b_q   <= in2;
                        w_q   <= in1;
                        op_q  <= op;
                        cnt_q <= im;
                        wcf_q <= CF;
                    end
                end
                S_EXEC: begin
                    if (ex_wr) res <= ex_res;
                    if (ex_fl) begin
                        CF <= ex_cf;
                        OF <= ex_of;
                    end
                    if (ex_zs) begin
                        ZF <= (ex_res == '0);
                        SF <= ex_res[MSB];
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        w_q   <= st_w;
                        wcf_q <= st_c;
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        res <= w_q;
                        CF  <= wcf_q;
                        ZF  <= (w_q == '0);
                        SF  <= w_q[MSB];
                        OF  <= sh_of;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: vector table, directed corner cases and random ops
// checked against a behavioural model, on WIDTH=8 and WIDTH=16 instances.
module tb_alu_seq_param;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        v8 = 1'b0, v16 = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in1 = '0, in2 = '0;
    logic [3:0]  im = '0;
    logic [4:0]  op = '0;

    logic        rdy8, ov8, cf8, zf8, sf8, of8, bz8;
    logic [7:0]  r8;
    logic        rdy16, ov16, cf16, zf16, sf16, of16, bz16;
    logic [15:0] r16;

    always #5 clock = ~clock;

    alu_seq_param #(.WIDTH(8), .SH_W(3)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(v8), .in_ready(rdy8),
        .in1(in1[7:0]), .in2(in2[7:0]), .im(im[2:0]), .op(op),
        .out_valid(ov8), .out_ready(out_ready), .res(r8),
        .CF(cf8), .ZF(zf8), .SF(sf8), .OF(of8), .busy(bz8)
    );

    alu_seq_param #(.WIDTH(16), .SH_W(4)) dut16 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(v16), .in_ready(rdy16),
        .in1(in1), .in2(in2), .im(im), .op(op),
        .out_valid(ov16), .out_ready(out_ready), .res(r16),
        .CF(cf16), .ZF(zf16), .SF(sf16), .OF(of16), .busy(bz16)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] mres[2];
    logic [3:0]  mfl[2];

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          n;
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t tv[17];
    vec_t tw[2];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic rdy(input int k);
        return (k == 0) ? rdy8 : rdy16;
    endfunction

    function automatic logic ovf(input int k);
        return (k == 0) ? ov8 : ov16;
    endfunction

    function automatic logic bzf(input int k);
        return (k == 0) ? bz8 : bz16;
    endfunction

    function automatic logic [15:0] gres(input int k);
        return (k == 0) ? {8'h00, r8} : r16;
    endfunction

    function automatic logic [3:0] gfl(input int k);
        return (k == 0) ? {cf8, zf8, sf8, of8} : {cf16, zf16, sf16, of16};
    endfunction

    // Reference model: whole-operation arithmetic, flags {CF,ZF,SF,OF}
    task automatic mdl(input int w, input logic [4:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int n, inout logic [31:0] r,
                       inout logic [3:0] f);
        logic [63:0] mask, s;
        logic [31:0] nr, m32;
        logic        cf, of;
        bit          wr, fl, zs;
        int          m;
        m    = w - 1;
        mask = (64'h1 << w) - 1;
        m32  = mask[31:0];
        nr   = r;
        cf   = f[3];
        of   = f[0];
        wr   = 1;
        fl   = 1;
        zs   = 1;
        case (o)
            5'd1, 5'd7: begin
                s  = 64'(a) + 64'(b) + ((o == 5'd7) ? 64'(f[3]) : 64'd0);
                nr = s[31:0] & m32;
                cf = s[w];
                of = (a[m] == b[m]) && (nr[m] != a[m]);
            end
            5'd3: begin
                nr = (a - b) & m32;
                cf = (a < b);
                of = (a[m] != b[m]) && (nr[m] != a[m]);
            end
            5'd2: begin nr = a & b; cf = 0; of = 0; end
            5'd4: begin nr = a | b; cf = 0; of = 0; end
            5'd5: begin nr = a ^ b; cf = 0; of = 0; end
            5'd8: begin nr = ~a & m32; cf = 0; of = 0; end
            5'd6: begin nr = b; fl = 0; zs = 0; end
            5'd31: begin nr = a; fl = 0; zs = 0; end
            5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: begin
                if (n == 0) begin
                    nr = a;
                    of = 0;
                end else begin
                    case (o)
                        5'd9: begin
                            nr = (a >> n) | (a[m] ? (m32 & ~(m32 >> n)) : 0);
                            cf = a[n-1];
                        end
                        5'd10: begin nr = a >> n; cf = a[n-1]; end
                        5'd13: begin
                            nr = ((a << n) | (a >> (w - n))) & m32;
                            cf = nr[0];
                        end
                        5'd14: begin
                            nr = ((a >> n) | (a << (w - n))) & m32;
                            cf = nr[m];
                        end
                        default: begin
                            nr = (a << n) & m32;
                            cf = a[w-n];
                        end
                    endcase
                    if (o == 5'd9)       of = 0;
                    else if (o == 5'd10) of = a[m];
                    else                 of = a[m] ^ nr[m];
                end
            end
            default: begin wr = 0; fl = 0; zs = 0; end
        endcase
        if (wr) r = nr;
        if (fl) begin f[3] = cf; f[0] = of; end
        if (zs) begin f[2] = (nr == 0); f[1] = nr[m]; end
    endtask

    // Issue one op, wait for its result, consume it
    task automatic run(input int w, input logic [4:0] o,
                       input logic [15:0] a, input logic [15:0] b,
                       input int n, output logic [15:0] gr,
                       output logic [3:0] gf, output int lat,
                       output int bcnt);
        int k, g;
        k = (w == 8) ? 0 : 1;
        g = 0;
        while (!rdy(k) && g < 50) begin
            @(posedge clock); #1; g++;
        end
        if (g == 50) chk("ready_timeout", 0, 1);
        in1 = a;
        in2 = b;
        op  = o;
        im  = n[3:0];
        if (k == 0) v8 = 1'b1; else v16 = 1'b1;
        @(posedge clock); #1;
        v8  = 1'b0;
        v16 = 1'b0;
        mdl(w, o, {16'h0, a}, {16'h0, b}, n, mres[k], mfl[k]);
        lat  = 0;
        bcnt = 0;
        while (!ovf(k) && lat < 40) begin
            if (bzf(k)) bcnt++;
            @(posedge clock); #1; lat++;
        end
        gr = gres(k);
        gf = gfl(k);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] gr, a, b;
        logic [3:0]  gf;
        logic [4:0]  o;
        int          lat, bc, n, el;

        tv[0]  = '{5'd1,  16'h7F, 16'h01, 0, 16'h80, 4'b0011, 1};
        tv[1]  = '{5'd1,  16'hFF, 16'h01, 0, 16'h00, 4'b1100, 1};
        tv[2]  = '{5'd7,  16'h10, 16'h20, 0, 16'h31, 4'b0000, 1};
        tv[3]  = '{5'd3,  16'h05, 16'h07, 0, 16'hFE, 4'b1010, 1};
        tv[4]  = '{5'd3,  16'h80, 16'h01, 0, 16'h7F, 4'b0001, 1};
        tv[5]  = '{5'd9,  16'h90, 16'h00, 3, 16'hF2, 4'b0010, 4};
        tv[6]  = '{5'd13, 16'h81, 16'h00, 1, 16'h03, 4'b1001, 2};
        tv[7]  = '{5'd14, 16'h01, 16'h00, 7, 16'h02, 4'b0000, 8};
        tv[8]  = '{5'd12, 16'h81, 16'h00, 0, 16'h81, 4'b0010, 1};
        tv[9]  = '{5'd6,  16'h00, 16'h55, 0, 16'h55, 4'b0010, 1};
        tv[10] = '{5'd0,  16'h12, 16'h34, 0, 16'h55, 4'b0010, 1};
        tv[11] = '{5'd5,  16'hF0, 16'hF0, 0, 16'h00, 4'b0100, 1};
        tv[12] = '{5'd10, 16'h81, 16'h00, 1, 16'h40, 4'b1001, 2};
        tv[13] = '{5'd31, 16'hA5, 16'h00, 0, 16'hA5, 4'b1001, 1};
        tv[14] = '{5'd16, 16'h11, 16'h22, 0, 16'hA5, 4'b1001, 1};
        tv[15] = '{5'd8,  16'hFF, 16'h00, 0, 16'h00, 4'b0100, 1};
        tv[16] = '{5'd11, 16'h40, 16'h00, 1, 16'h80, 4'b0011, 2};
        tw[0]  = '{5'd1,  16'h7FFF, 16'h0001, 0, 16'h8000, 4'b0011, 1};
        tw[1]  = '{5'd9,  16'h9000, 16'h0000, 3, 16'hF200, 4'b0010, 4};

        mres[0] = '0; mres[1] = '0;
        mfl[0]  = '0; mfl[1]  = '0;

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        chk("rst_res", {24'h0, r8}, 0);
        chk("rst_flags", {28'h0, cf8, zf8, sf8, of8}, 0);
        chk("rst_ctl", {29'h0, ov8, bz8, rdy8}, 32'h1);

        for (int i = 0; i < 17; i++) begin
            run(8, tv[i].op, tv[i].a, tv[i].b, tv[i].n, gr, gf, lat, bc);
            chk($sformatf("vec%0d_res", i), {16'h0, gr}, {16'h0, tv[i].r});
            chk($sformatf("vec%0d_flags", i), {28'h0, gf}, {28'h0, tv[i].f});
            chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("vec%0d_busy", i), bc, tv[i].lat - 1);
        end

        // Result held while out_ready is low; new requests ignored
        in1 = 16'h03; in2 = 16'h04; op = 5'd1; im = '0;
        v8 = 1'b1;
        @(posedge clock); #1;
        v8 = 1'b0;
        mdl(8, 5'd1, 32'h3, 32'h4, 0, mres[0], mfl[0]);
        @(posedge clock); #1;
        in1 = 16'h09; op = 5'd3; v8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_res", i), {24'h0, r8}, mres[0]);
            chk($sformatf("hold%0d_ctl", i), {30'h0, ov8, rdy8}, 32'h2);
            @(posedge clock); #1;
        end
        v8 = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("hold_idle", {31'h0, rdy8}, 1);
        @(posedge clock); #1;
        chk("hold_noqueue", {30'h0, ov8, rdy8}, 32'h1);
        chk("hold_flags", {28'h0, cf8, zf8, sf8, of8}, {28'h0, mfl[0]});

        for (int i = 0; i < 200; i++) begin
            o = 5'($urandom_range(0, 31));
            a = 16'($urandom_range(0, 255));
            b = 16'($urandom_range(0, 255));
            n = $urandom_range(0, 7);
            el = (o >= 5'd9 && o <= 5'd14 && n != 0) ? n + 1 : 1;
            run(8, o, a, b, n, gr, gf, lat, bc);
            chk($sformatf("rnd8_%0d_res op%0d", i, o), {16'h0, gr}, mres[0]);
            chk($sformatf("rnd8_%0d_flags op%0d", i, o), {28'h0, gf},
                {28'h0, mfl[0]});
            chk($sformatf("rnd8_%0d_lat", i), lat, el);
        end

        // Reset in the middle of a shift
        in1 = 16'h96; op = 5'd10; im = 4'd7; v8 = 1'b1;
        @(posedge clock); #1;
        v8 = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("midshift_busy", {31'h0, bz8}, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_res", {24'h0, r8}, 0);
        chk("midrst_flags", {28'h0, cf8, zf8, sf8, of8}, 0);
        chk("midrst_ctl", {29'h0, ov8, bz8, rdy8}, 32'h1);
        mres[0] = '0; mres[1] = '0;
        mfl[0]  = '0; mfl[1]  = '0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        repeat (10) begin
            @(posedge clock); #1;
        end
        chk("postrst_idle", {29'h0, ov8, bz8, rdy8}, 32'h1);

        for (int i = 0; i < 2; i++) begin
            run(16, tw[i].op, tw[i].a, tw[i].b, tw[i].n, gr, gf, lat, bc);
            chk($sformatf("w16vec%0d_res", i), {16'h0, gr}, {16'h0, tw[i].r});
            chk($sformatf("w16vec%0d_flags", i), {28'h0, gf},
                {28'h0, tw[i].f});
            chk($sformatf("w16vec%0d_lat", i), lat, tw[i].lat);
            chk($sformatf("w16vec%0d_busy", i), bc, tw[i].lat - 1);
        end

        for (int i = 0; i < 100; i++) begin
            o = 5'($urandom_range(0, 31));
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            n = $urandom_range(0, 15);
            el = (o >= 5'd9 && o <= 5'd14 && n != 0) ? n + 1 : 1;
            run(16, o, a, b, n, gr, gf, lat, bc);
            chk($sformatf("rnd16_%0d_res op%0d", i, o), {16'h0, gr}, mres[1]);
            chk($sformatf("rnd16_%0d_flags op%0d", i, o), {28'h0, gf},
                {28'h0, mfl[1]});
            chk($sformatf("rnd16_%0d_lat", i), lat, el);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
